// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side byte buffer.
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic {
        TXF_IDLE,
        TXF_HOLD
    } txf_state_t;

    localparam int unsigned UART_TXF_DEPTH_DEF = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// Flop-array byte storage: one synchronous write port, combinational read at raddr.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_TXF_DEPTH_DEF,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  uart_byte_t    wdata,
    input  logic [AW-1:0] raddr,
    output uart_byte_t    rdata
);

    // Contents are deliberately left unreset; count gates every read.
    uart_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter through a tx_load/tx_ready handshake,
// with sticky overflow, synchronous flush and a two-state drain FSM.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_TXF_DEPTH_DEF,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             wr_en,
    input  uart_byte_t       wr_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic             clr_ovf,
    input  logic             flush,
    output logic             tx_load,
    output uart_byte_t       tx_data,
    input  logic             tx_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             tx_load_q, tx_load_d;
    uart_byte_t       tx_data_q, tx_data_d;
    txf_state_t       state_q, state_d;
    uart_byte_t       rd_data;
    logic             push, pop, ovf_set;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A full FIFO refuses the byte even when a pop happens in the same cycle.
    assign push    = wr_en && !full && !flush;
    assign ovf_set = wr_en && full && !flush;
    assign pop     = (state_q == TXF_IDLE) && !empty && tx_ready && !flush;

    uart_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr_q),
        .wdata(wr_data),
        .raddr(rd_ptr_q),
        .rdata(rd_data)
    );

    always_comb begin
        state_d   = state_q;
        tx_load_d = 1'b0;
        tx_data_d = tx_data_q;
        case (state_q)
            TXF_IDLE: begin
                if (pop) begin
                    tx_load_d = 1'b1;
                    tx_data_d = rd_data;
                    state_d   = TXF_HOLD;
                end
            end
            TXF_HOLD: state_d = TXF_IDLE;
            default:  state_d = TXF_IDLE;
        endcase
        if (flush) begin
            state_d = TXF_IDLE;
        end
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        overflow_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_load_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            state_q    <= TXF_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_load_q  <= tx_load_d;
            tx_data_q  <= tx_data_d;
            state_q    <= state_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_load  = tx_load_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: expected bytes are queued when pushed and
// compared in order whenever the DUT strobes tx_load.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             nrst;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             clr_ovf;
    logic             flush;
    logic             tx_load;
    logic [7:0]       tx_data;
    logic             tx_ready;

    int errors = 0;
    int checks = 0;
    int loads  = 0;
    logic [7:0] sb[$];
    logic prev_load  = 1'b0;
    logic prev_ready = 1'b0;

    uart_tx_fifo #(
        .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow),
        .clr_ovf (clr_ovf),
        .flush   (flush),
        .tx_load (tx_load),
        .tx_data (tx_data),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_accept) sb.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk("drain_done", 32'(sb.size()), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
    endtask

    // Scoreboard consumer: every strobe must match the oldest queued byte.
    always @(negedge clk) begin
        if (nrst && tx_load) begin
            loads++;
            chk("no_back_to_back", 32'(prev_load), 32'd0);
            chk("ready_before_load", 32'(prev_ready), 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_load", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                chk("tx_data_order", 32'(tx_data), 32'(sb.pop_front()));
            end
        end
        prev_load  = nrst && tx_load;
        prev_ready = tx_ready;
    end

    initial begin
        int loads_snap;

        nrst = 1'b0; wr_en = 1'b1; wr_data = 8'h5A;
        tx_ready = 1'b1; clr_ovf = 1'b0; flush = 1'b0;
        repeat (3) tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_tx_load", 32'(tx_load), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_overflow", 32'(overflow), 32'd0);
        wr_en = 1'b0;
        nrst  = 1'b1;
        tick();

        // Single byte latency: load appears one edge after the push edge.
        push_byte(8'hA5, 1'b1);
        chk("single_count1", 32'(count), 32'd1);
        chk("single_noload", 32'(tx_load), 32'd0);
        tick();
        chk("single_load", 32'(tx_load), 32'd1);
        chk("single_data", 32'(tx_data), 32'hA5);
        chk("single_count0", 32'(count), 32'd0);
        tick();
        chk("single_load_drop", 32'(tx_load), 32'd0);
        chk("single_data_held", 32'(tx_data), 32'hA5);

        // Backpressure, then one ready window per byte.
        tx_ready = 1'b0;
        loads_snap = loads;
        push_byte(8'h01, 1'b1);
        push_byte(8'h02, 1'b1);
        push_byte(8'h03, 1'b1);
        repeat (3) tick();
        chk("bp_count", 32'(count), 32'd3);
        chk("bp_noload", 32'(loads), 32'(loads_snap));
        for (int i = 0; i < 3; i++) begin
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            chk("bp_load", 32'(tx_load), 32'd1);
            chk("bp_data", 32'(tx_data), 32'(i + 1));
            chk("bp_count_dec", 32'(count), 32'(2 - i));
            repeat (2) tick();
        end

        // Fill to full; 17th push overflows even with clr_ovf asserted.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i), 1'b1);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_no_ovf", 32'(overflow), 32'd0);
        clr_ovf = 1'b1;
        push_byte(8'h20, 1'b0);
        clr_ovf = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'(DEPTH));
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        tx_ready = 1'b1;
        drain(200);
        chk("drain_empty", 32'(empty), 32'd1);

        // Half full, then push on every pop edge across several wraps.
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH / 2; i++) push_byte(8'(8'h40 + i), 1'b1);
        chk("half_count", 32'(count), 32'(DEPTH / 2));
        tx_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            push_byte(8'(8'h80 + i), 1'b1);
            chk("pp_count_pop", 32'(count), 32'(DEPTH / 2));
            tick();
            chk("pp_count_hold", 32'(count), 32'(DEPTH / 2));
        end
        drain(200);

        // Flush with a concurrent write; nothing may load afterwards.
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i), 1'b1);
        chk("flush_pre_count", 32'(count), 32'd5);
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        sb.delete();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        loads_snap = loads;
        tx_ready = 1'b1;
        repeat (6) tick();
        chk("flush_noload", 32'(loads), 32'(loads_snap));

        // Reset while the strobe is high (FSM in HOLD).
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(8'(8'hD0 + i), 1'b1);
        tx_ready = 1'b1;
        tick();
        chk("hold_load", 32'(tx_load), 32'd1);
        nrst = 1'b0;
        #1;
        chk("rst_hold_load", 32'(tx_load), 32'd0);
        chk("rst_hold_count", 32'(count), 32'd0);
        chk("rst_hold_empty", 32'(empty), 32'd1);
        sb.delete();
        tick();
        nrst = 1'b1;
        loads_snap = loads;
        repeat (6) tick();
        chk("rst_hold_noload", 32'(loads), 32'(loads_snap));
        chk("sb_final", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
